divconv_ctrl: RTL and testbench

Sequencer for the 8-bit Goldschmidt divide-by-convergence datapath `divconv`. On `start`, it drives the datapath's mux selects and register load enables through the fixed schedule: initial approximation, then the requested number of refinement iterations. It flags `done` in the cycle the quotient is valid on `q`. It sits beside `divconv` in the divider top level and has no arithmetic of its own.

---
 rtl/divconv_pkg.sv | 26 ++
 rtl/divconv_ctrl.sv | 118 +++++++++++
 tb/tb_divconv_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/divconv_pkg.sv
// Shared encodings for the divide-by-convergence controller and datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package divconv_pkg;

  // Controller schedule states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_N = 3'd2,
    MUL_N  = 3'd3,
    MUL_D  = 3'd4
  } state_e;

  // sel_muxa encodings: multiplier operand A.
  localparam logic [1:0] SELA_K  = 2'd0;  // rega_out, the correction factor K
  localparam logic [1:0] SELA_D  = 2'd1;  // divisor input d
  localparam logic [1:0] SELA_IA = 2'd2;  // initial reciprocal approximation

  // sel_muxb encodings: multiplier operand B.
  localparam logic [1:0] SELB_D    = 2'd0;  // divisor input d
  localparam logic [1:0] SELB_X    = 2'd1;  // dividend input x
  localparam logic [1:0] SELB_DREG = 2'd2;  // regb_out, running denominator D
  localparam logic [1:0] SELB_NREG = 2'd3;  // regc_out, running numerator N

endpackage

// File: rtl/divconv_ctrl.sv
// Sequencer for the Goldschmidt divide-by-convergence datapath: drives mux selects and load enables.
// Latency: INIT_D the cycle after start is sampled; done pulses 2n+1 cycles into the run (n = iterations, 0 read as 1).
// Backpressure: none; start is only accepted in IDLE, ignored (not queued) while busy or during the done cycle.
//
// Ports:
//   clk, reset_b        clock, asynchronous active-low reset
//   start, iters        begin a division with 'iters' refinement passes (sampled together in IDLE)
//   sel_muxa, sel_muxb  datapath multiplier operand selects
//   load_rega/b/c       datapath register load enables for K, D and N
//   busy, done          run in progress; final N update (quotient valid on q)
module divconv_ctrl
  import divconv_pkg::*;
#(
  parameter int ITER_W = 3
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  output logic [1:0]        sel_muxa,
  output logic [1:0]        sel_muxb,
  output logic              load_rega,
  output logic              load_regb,
  output logic              load_regc,
  output logic              busy,
  output logic              done
);

  localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  state_e            state_d;
  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] iters_q;
  logic              last_n;

  // cnt_q counts N multiplications already completed, so the current MUL_N
  // is the final one when one fewer than the requested count have finished.
  // iters_q is never 0 once captured, so the subtraction cannot wrap in use.
  assign last_n = (cnt_q == (iters_q - ITER_ONE));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            // A request for zero refinement passes runs one pass.
            iters_q <= (iters == '0) ? ITER_ONE : iters;
          end
        end
        MUL_N:   cnt_q <= cnt_q + ITER_ONE;
        default: ;
      endcase
    end
  end

  // Next state and Moore output decode; nothing below reads an input
  // except the IDLE start transition.
  always_comb begin
    state_d   = state_q;
    sel_muxa  = SELA_K;
    sel_muxb  = SELB_D;
    load_rega = 1'b0;
    load_regb = 1'b0;
    load_regc = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = INIT_D;
      end
      INIT_D: begin
        // D0 = IA*d into regb; K1 = 2 - D0 into rega from the same product.
        sel_muxa  = SELA_IA;
        sel_muxb  = SELB_D;
        load_rega = 1'b1;
        load_regb = 1'b1;
        state_d   = INIT_N;
      end
      INIT_N: begin
        // N0 = IA*x.
        sel_muxa  = SELA_IA;
        sel_muxb  = SELB_X;
        load_regc = 1'b1;
        state_d   = MUL_N;
      end
      MUL_N: begin
        // Ni = Ni-1 * Ki; the last of these leaves the quotient on q.
        sel_muxa  = SELA_K;
        sel_muxb  = SELB_NREG;
        load_regc = 1'b1;
        done      = last_n;
        state_d   = last_n ? IDLE : MUL_D;
      end
      MUL_D: begin
        // Di = Di-1 * Ki; Ki+1 = 2 - Di.
        sel_muxa  = SELA_K;
        sel_muxb  = SELB_DREG;
        load_rega = 1'b1;
        load_regb = 1'b1;
        state_d   = MUL_N;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_divconv_ctrl.sv
// Scoreboard bench for divconv_ctrl: stimulus pushes the expected per-cycle output trace,
// a monitor pops and compares one entry per cycle while enabled, or on demand for async checks.
module tb_divconv_ctrl;

  localparam int ITER_W = 3;

  // Expected vector layout: {sel_muxa, sel_muxb, load_rega, load_regb, load_regc, busy, done}
  localparam logic [8:0] V_IDLE   = 9'b00_00_000_0_0;
  localparam logic [8:0] V_INITD  = 9'b10_00_110_1_0;
  localparam logic [8:0] V_INITN  = 9'b10_01_001_1_0;
  localparam logic [8:0] V_MULN   = 9'b00_11_001_1_0;
  localparam logic [8:0] V_MULN_L = 9'b00_11_001_1_1;
  localparam logic [8:0] V_MULD   = 9'b00_10_110_1_0;

  logic              clk;
  logic              reset_b;
  logic              start;
  logic [ITER_W-1:0] iters;
  logic [1:0]        sel_muxa;
  logic [1:0]        sel_muxb;
  logic              load_rega;
  logic              load_regb;
  logic              load_regc;
  logic              busy;
  logic              done;

  divconv_ctrl #(.ITER_W(ITER_W)) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .start    (start),
    .iters    (iters),
    .sel_muxa (sel_muxa),
    .sel_muxb (sel_muxb),
    .load_rega(load_rega),
    .load_regb(load_regb),
    .load_regc(load_regc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] exp_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  bit         mon_on     = 0;
  bit         snap_req   = 0;
  bit         finish_req = 0;
  string      cur_test   = "init";
  event       snap_ev;

  function automatic logic [8:0] act_vec();
    return {sel_muxa, sel_muxb, load_rega, load_regb, load_regc, busy, done};
  endfunction

  // Monitor: the only process that steps the comparison counters.
  initial begin
    logic [8:0] e;
    logic [8:0] a;
    forever begin
      @(negedge clk or snap_ev);
      if (finish_req) begin
        compared++;
        if (exp_q.size() != 0) begin
          mismatched++;
          $display("FAIL drain: %0d expected cycles never observed, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end else if (snap_req) begin
        snap_req = 0;
        a = act_vec();
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL %s: async check with no expectation queued, got %b", cur_test, a);
        end else begin
          e = exp_q.pop_front();
          compared++;
          if (a !== e) begin
            mismatched++;
            $display("FAIL %s: outputs %b, required %b (sa_sb_loads_busy_done)", cur_test, a, e);
          end
        end
      end else if (mon_on) begin
        a = act_vec();
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          compared++;
          if (a !== e) begin
            mismatched++;
            $display("FAIL %s @%0t: outputs %b, required %b (sa_sb_loads_busy_done)", cur_test, $time, a, e);
          end
        end else if (busy || done || load_rega || load_regb || load_regc) begin
          compared++;
          mismatched++;
          $display("FAIL %s @%0t: unexpected activity %b, required %b", cur_test, $time, a, V_IDLE);
        end
      end
    end
  end

  task automatic push_idle(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back(V_IDLE);
  endtask

  // Reference schedule: INIT_D, INIT_N, then n MUL_N with MUL_D between them.
  task automatic push_run(input int n);
    int eff;
    eff = (n == 0) ? 1 : n;
    exp_q.push_back(V_INITD);
    exp_q.push_back(V_INITN);
    for (int i = 1; i <= eff; i++) begin
      if (i == eff) begin
        exp_q.push_back(V_MULN_L);
      end else begin
        exp_q.push_back(V_MULN);
        exp_q.push_back(V_MULD);
      end
    end
  endtask

  // Wait (at posedge+1) until at most k expectations remain; bounded.
  task automatic wait_drain(input int k);
    int budget;
    budget = 200;
    while (exp_q.size() > k && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
  endtask

  task automatic pulse_run(input string name, input int n);
    cur_test = name;
    @(posedge clk);
    #1;
    start = 1'b1;
    iters = ITER_W'(n);
    push_idle(1);
    push_run(n);
    push_idle(1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(0);
  endtask

  initial begin
    int budget;
    reset_b = 1'b0;
    start   = 1'b0;
    iters   = '0;

    // Reset state while held in reset.
    #3;
    cur_test = "reset_state";
    exp_q.push_back(V_IDLE);
    snap_req = 1;
    ->snap_ev;
    repeat (3) @(posedge clk);
    #2;
    reset_b = 1'b1;

    // Stays idle after release with start low.
    cur_test = "idle_after_reset";
    mon_on = 1;
    push_idle(4);
    wait_drain(0);

    pulse_run("iters1", 1);
    pulse_run("iters3", 3);
    pulse_run("iters0_as_1", 0);
    pulse_run("iters7_max", 7);

    // start pulsed mid-run and in the done cycle: both ignored.
    cur_test = "start_while_busy";
    @(posedge clk);
    #1;
    start = 1'b1;
    iters = 3'd2;
    push_idle(1);
    push_run(2);
    push_idle(2);
    @(posedge clk); #1; start = 1'b0;   // now in INIT_D
    @(posedge clk); #1; start = 1'b1;   // INIT_N: ignored
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;                 // MUL_D
    @(posedge clk); #1; start = 1'b1;   // final MUL_N (done): ignored
    @(posedge clk); #1; start = 1'b0;
    wait_drain(0);

    // start held high: runs separated by exactly one idle cycle.
    cur_test = "start_held";
    @(posedge clk);
    #1;
    start = 1'b1;
    iters = 3'd1;
    push_idle(1);
    push_run(1);
    push_idle(1);
    push_run(1);
    push_idle(1);
    push_run(1);
    push_idle(2);
    wait_drain(2);
    start = 1'b0;
    wait_drain(0);

    // Reset during MUL_D, then a clean iters=2 run.
    cur_test = "reset_mid_run";
    @(posedge clk);
    #1;
    start = 1'b1;
    iters = 3'd3;
    push_idle(1);
    exp_q.push_back(V_INITD);
    exp_q.push_back(V_INITN);
    exp_q.push_back(V_MULN);
    exp_q.push_back(V_MULD);
    @(posedge clk);
    #1;
    start = 1'b0;
    budget = 50;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    reset_b = 1'b0;
    #1;
    cur_test = "async_reset_mid_run";
    exp_q.push_back(V_IDLE);
    snap_req = 1;
    ->snap_ev;
    repeat (2) @(posedge clk);
    #2;
    reset_b = 1'b1;
    pulse_run("after_reset_iters2", 2);

    cur_test = "tail";
    push_idle(3);
    wait_drain(0);

    #1;
    finish_req = 1;
    ->snap_ev;
    #100;
    $display("FAIL watchdog: monitor did not finish");
    $fatal(1);
  end

endmodule
